// File: rtl/sample_stream_uart_if.sv
// rtl/sample_stream_uart_if.sv - sample source / UART status bundle for sample_stream_uart
// Purpose: groups the sample-side inputs and the UART/status outputs of the streamer.
// Ports (master = sample source / host side, slave = streamer):
//   sample_clk   codec sample clock, rising edge is the strobe
//   enable       permit new frames
//   samples      N_CH*W packed signed samples, channel 0 in [W-1:0]
//   tx_o         UART TX line, 8N1, idle high
//   busy         frame in progress
//   overrun_cnt  saturating count of triggers lost while busy
interface sample_stream_uart_if #(
  parameter int W    = 16,
  parameter int N_CH = 4
);
  logic                sample_clk;
  logic                enable;
  logic [N_CH*W-1:0]   samples;
  logic                tx_o;
  logic                busy;
  logic [7:0]          overrun_cnt;

  modport master (
    output sample_clk, enable, samples,
    input  tx_o, busy, overrun_cnt
  );

  modport slave (
    input  sample_clk, enable, samples,
    output tx_o, busy, overrun_cnt
  );
endinterface

// File: rtl/sample_stream_uart.sv
// rtl/sample_stream_uart.sv - framed, sequence-numbered multi-channel sample streamer over UART
// Purpose: on every DECIMATE-th rising edge of sample_clk, snapshot N_CH samples and send
//   A5, seq, channel bytes (MSB first per channel), XOR checksum as 8N1 UART bytes.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    sample_stream_uart_if.slave: sample_clk, enable, samples in; tx_o, busy, overrun_cnt out
module sample_stream_uart #(
  parameter int W         = 16,
  parameter int N_CH      = 4,
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 1_000_000,
  parameter int DECIMATE  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sample_stream_uart_if.slave  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BPS          = W / 8;
  localparam int N_DATA       = N_CH * BPS;
  localparam int FRAME_BYTES  = 2 + N_DATA + 1;
  localparam int DCW          = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int BCW          = $clog2(CLKS_PER_BIT);
  localparam int IXW          = $clog2(FRAME_BYTES);

  generate
    if ((W % 8) != 0 || W < 8) begin : g_bad_w
      $error("sample_stream_uart: W must be a positive multiple of 8");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("sample_stream_uart: N_CH must be 1..16");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("sample_stream_uart: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DECIMATE < 1 || DECIMATE > 256) begin : g_bad_dec
      $error("sample_stream_uart: DECIMATE must be 1..256");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic                sample_clk_q, sample_clk_d;
  logic [DCW-1:0]      dcnt_q, dcnt_d;
  logic [BCW-1:0]      bcnt_q, bcnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [IXW-1:0]      bidx_q, bidx_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [N_CH*W-1:0]   shadow_q, shadow_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  logic                strobe, trigger, bit_end;
  logic [7:0]          data_bytes [N_DATA];
  logic [7:0]          chk;
  logic [7:0]          cur_byte;

  // Data byte i in frame order: channel i/BPS, most significant byte of that channel first.
  for (genvar i = 0; i < N_DATA; i++) begin : g_bytes
    assign data_bytes[i] = shadow_q[(i / BPS) * W + (BPS - 1 - (i % BPS)) * 8 +: 8];
  end

  always_comb begin
    chk = seq_q;
    for (int i = 0; i < N_DATA; i++) chk = chk ^ data_bytes[i];
  end

  // Byte selected by the frame index; the final index carries the checksum.
  always_comb begin
    cur_byte = chk;
    if (bidx_q == '0) cur_byte = 8'hA5;
    else if (bidx_q == IXW'(1)) cur_byte = seq_q;
    for (int i = 0; i < N_DATA; i++) begin
      if (bidx_q == IXW'(i + 2)) cur_byte = data_bytes[i];
    end
  end

  assign strobe  = bus.sample_clk & ~sample_clk_q;
  assign trigger = strobe && (dcnt_q == '0);
  assign bit_end = (bcnt_q == BCW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d      = state_q;
    sample_clk_d = bus.sample_clk;
    dcnt_d       = dcnt_q;
    bcnt_d       = bcnt_q;
    bit_d        = bit_q;
    bidx_d       = bidx_q;
    tx_byte_d    = tx_byte_q;
    shadow_d     = shadow_q;
    seq_d        = seq_q;
    ovr_d        = ovr_q;
    tx_d         = tx_q;
    busy_d       = busy_q;

    if (strobe) begin
      dcnt_d = (dcnt_q == DCW'(DECIMATE - 1)) ? '0 : dcnt_q + DCW'(1);
    end

    case (state_q)
      S_START: begin
        bcnt_d = bit_end ? '0 : bcnt_q + BCW'(1);
        if (bit_end) begin
          state_d   = S_DATA;
          tx_byte_d = cur_byte;
          tx_d      = cur_byte[0];
          bit_d     = '0;
        end
      end
      S_DATA: begin
        bcnt_d = bit_end ? '0 : bcnt_q + BCW'(1);
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d     = bit_q + 3'd1;
            tx_byte_d = {1'b0, tx_byte_q[7:1]};
            tx_d      = tx_byte_q[1];
          end
        end
      end
      S_STOP: begin
        bcnt_d = bit_end ? '0 : bcnt_q + BCW'(1);
        if (bit_end) begin
          if (bidx_q == IXW'(FRAME_BYTES - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            seq_d   = seq_q + 8'd1;
          end else begin
            state_d = S_START;
            bidx_d  = bidx_q + IXW'(1);
            tx_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // busy_q is still high on the edge that ends the last stop bit, so a trigger
    // landing there is counted as an overrun rather than chained into a new frame.
    if (trigger && bus.enable) begin
      if (busy_q) begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end else begin
        shadow_d = bus.samples;
        bidx_d   = '0;
        bcnt_d   = '0;
        state_d  = S_START;
        tx_d     = 1'b0;
        busy_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sample_clk_q <= 1'b1;
      dcnt_q       <= '0;
      bcnt_q       <= '0;
      bit_q        <= '0;
      bidx_q       <= '0;
      tx_byte_q    <= '0;
      shadow_q     <= '0;
      seq_q        <= '0;
      ovr_q        <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_clk_q <= sample_clk_d;
      dcnt_q       <= dcnt_d;
      bcnt_q       <= bcnt_d;
      bit_q        <= bit_d;
      bidx_q       <= bidx_d;
      tx_byte_q    <= tx_byte_d;
      shadow_q     <= shadow_d;
      seq_q        <= seq_d;
      ovr_q        <= ovr_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.tx_o        = tx_q;
  assign bus.busy        = busy_q;
  assign bus.overrun_cnt = ovr_q;
endmodule

// File: tb/tb_sample_stream_uart.sv
// tb/tb_sample_stream_uart.sv - directed self-checking bench for sample_stream_uart
module tb_sample_stream_uart;
  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passes = 0;

  localparam logic [63:0] S1 = 64'hDEF0_9ABC_5678_1234;
  localparam logic [63:0] S2 = 64'hA55A_7FFF_8000_0102;
  localparam logic [63:0] S3 = 64'h0F0F_CAFE_00FF_BEEF;
  localparam logic [63:0] S4 = 64'h1111_2222_4444_8888;

  always #5 clk = ~clk;

  sample_stream_uart_if #(.W(16), .N_CH(4)) b1 ();
  sample_stream_uart_if #(.W(16), .N_CH(4)) b16 ();

  sample_stream_uart #(.DECIMATE(1)) u_d1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  sample_stream_uart #(.DECIMATE(16)) u_d16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected frame byte n for a given seq and 4x16-bit sample word.
  function automatic logic [7:0] exp_byte(input logic [7:0] seq, input logic [63:0] smp, input int n);
    logic [7:0] x;
    if (n == 0) return 8'hA5;
    if (n == 1) return seq;
    if (n == 10) begin
      x = seq;
      for (int j = 0; j < 8; j++) x ^= smp[(j / 2) * 16 + ((j % 2 == 0) ? 8 : 0) +: 8];
      return x;
    end
    return smp[((n - 2) / 2) * 16 + (((n - 2) % 2 == 0) ? 8 : 0) +: 8];
  endfunction

  // Raises a strobe; returns #1 after the strobe edge T.
  task automatic strobe(input bit sel);
    if (sel) b16.sample_clk = 1'b0; else b1.sample_clk = 1'b0;
    @(posedge clk); #1;
    if (sel) b16.sample_clk = 1'b1; else b1.sample_clk = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called #1 after trigger edge T; samples bit k at T+6+12k.
  // act_kind: 0 none, 1 drop enable, 2 overwrite samples, 3 assert reset (aborts).
  task automatic rx_frame(input bit sel, input logic [7:0] seq, input logic [63:0] smp,
                          input int act_bit, input int act_kind, input string tag,
                          output logic [87:0] frame);
    logic [7:0] got;
    logic       t;
    bit         framing_ok;
    framing_ok = 1'b1;
    got        = '0;
    frame      = '0;
    for (int k = 0; k < 110; k++) begin
      repeat ((k == 0) ? 6 : 12) @(posedge clk);
      #1;
      t = sel ? b16.tx_o : b1.tx_o;
      if (k % 10 == 0) begin
        if (t !== 1'b0) framing_ok = 1'b0;
      end else if (k % 10 == 9) begin
        if (t !== 1'b1) framing_ok = 1'b0;
        frame = {frame[79:0], got};
        chk(got, exp_byte(seq, smp, k / 10), $sformatf("%s_byte%0d", tag, k / 10));
      end else begin
        got = {t, got[7:1]};
      end
      if (k == act_bit) begin
        if (act_kind == 1) begin
          if (sel) b16.enable = 1'b0; else b1.enable = 1'b0;
        end else if (act_kind == 2) begin
          if (sel) b16.samples = {4{16'hFFFF}}; else b1.samples = {4{16'hFFFF}};
        end else if (act_kind == 3) begin
          rst_n = 1'b0;
          #1;
          chk(sel ? b16.tx_o : b1.tx_o, 1, {tag, "_abort_tx"});
          chk(sel ? b16.busy : b1.busy, 0, {tag, "_abort_busy"});
          return;
        end
      end
    end
    chk(framing_ok, 1, {tag, "_framing"});
  endtask

  // Continues from the last rx sample (T+1314): busy high through T+1319, low after T+1320.
  task automatic finish_frame(input bit sel, input string tag);
    repeat (5) @(posedge clk);
    #1;
    chk(sel ? b16.busy : b1.busy, 1, {tag, "_busy_last"});
    @(posedge clk);
    #1;
    chk(sel ? b16.busy : b1.busy, 0, {tag, "_busy_clear"});
    chk(sel ? b16.tx_o : b1.tx_o, 1, {tag, "_idle_tx"});
  endtask

  initial begin
    logic [87:0] f;
    bit          bad;
    bit          pre;
    int          starts;

    rst_n          = 1'b0;
    b1.sample_clk  = 1'b0;
    b1.enable      = 1'b1;
    b1.samples     = S1;
    b16.sample_clk = 1'b0;
    b16.enable     = 1'b1;
    b16.samples    = S4;
    repeat (3) @(posedge clk);
    #1;
    chk(b1.tx_o, 1, "reset_tx");
    chk(b1.busy, 0, "reset_busy");
    chk(b1.overrun_cnt, 0, "reset_ovr");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with hand-computed bytes.
    strobe(0);
    chk(b1.busy, 1, "t1_busy_rise");
    chk(b1.tx_o, 0, "t1_start_bit");
    rx_frame(0, 8'h00, S1, -1, 0, "t1", f);
    total++;
    assert (f === 88'hA5_00_12_34_56_78_9A_BC_DE_F0_00) passes++;
    else $error("FAIL t1_frame: observed %h expected %h", f, 88'hA5_00_12_34_56_78_9A_BC_DE_F0_00);
    finish_frame(0, "t1");

    // Enable dropped mid-frame: frame still completes with seq 01.
    strobe(0);
    rx_frame(0, 8'h01, S1, 25, 1, "endrop", f);
    finish_frame(0, "endrop");

    // 64 strobes with enable low: line stays idle, no overruns.
    bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      strobe(0);
      for (int j = 0; j < 126; j++) begin
        @(negedge clk);
        if (b1.tx_o !== 1'b1 || b1.busy !== 1'b0) bad = 1'b1;
      end
    end
    chk(bad, 0, "en_off_idle");
    chk(b1.overrun_cnt, 0, "en_off_ovr");

    // Samples overwritten during byte 4: latched values and checksum; seq still 02.
    b1.enable  = 1'b1;
    b1.samples = S2;
    strobe(0);
    rx_frame(0, 8'h02, S2, 45, 2, "latch", f);
    finish_frame(0, "latch");

    // Continuous 128-cycle strobes: strobes 1..10 overrun, strobe 11 starts seq 04.
    b1.samples = S2;
    for (int i = 0; i < 11; i++) begin
      strobe(0);
      if (i == 0) chk(b1.busy, 1, "ovr_first_busy");
      repeat (126) @(posedge clk);
    end
    strobe(0);
    chk(b1.overrun_cnt, 10, "ovr_count10");
    chk(b1.busy, 1, "ovr_s11_busy");
    chk(b1.tx_o, 0, "ovr_s11_start");
    rx_frame(0, 8'h04, S2, -1, 0, "ovr_s11", f);
    finish_frame(0, "ovr_s11");

    // 300 fast strobes: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      strobe(0);
      repeat (2) @(posedge clk);
    end
    #1;
    chk(b1.overrun_cnt, 255, "ovr_saturate");
    for (int i = 0; i < 3000 && b1.busy !== 1'b0; i++) @(posedge clk);
    #1;
    chk(b1.busy, 0, "sat_idle_wait");

    // Reset during byte 3 aborts; next frame restarts at seq 00.
    b1.samples = S3;
    strobe(0);
    rx_frame(0, 8'h06, S3, 35, 3, "rst", f);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(b1.overrun_cnt, 0, "rst_ovr_clear");
    chk(b1.tx_o, 1, "rst_tx_idle");
    strobe(0);
    chk(b1.busy, 1, "rst_next_busy");
    rx_frame(0, 8'h00, S3, -1, 0, "rst_next", f);
    finish_frame(0, "rst_next");

    // DECIMATE=16: 48 strobes give frames at strobes 0, 16, 32 with seq 00..02.
    starts = 0;
    for (int i = 0; i < 48; i++) begin
      pre = b16.busy;
      strobe(1);
      if (!pre && b16.busy === 1'b1) starts++;
      if (i % 16 == 0) begin
        rx_frame(1, 8'(i / 16), S4, -1, 0, $sformatf("dec_f%0d", i / 16), f);
        finish_frame(1, "dec");
      end else begin
        repeat (126) @(posedge clk);
      end
    end
    chk(starts, 3, "dec_frame_count");
    chk(b16.overrun_cnt, 0, "dec_ovr");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
